// File: rtl/sr_bank_writer_if.sv
// Request handshake bundle for sr_bank_writer: target word offered over valid/ready.
interface sr_bank_writer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/sr_bank_writer.sv
// Write-side controller for a bank of set/reset flip-flops: drive S/R bursts, settle, verify readback.
// Optional feature macro SR_RETRY_EN: one extra drive burst after a first readback mismatch.
module sr_bank_writer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  sr_bank_writer_if.slave   req,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  sr_s,
  output logic [WIDTH-1:0]  sr_r,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [WIDTH-1:0]  err_mask
);

  localparam int unsigned MAXC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] S_LD = (SETTLE_CYCLES > 0) ? CW'(SETTLE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_rst;
  logic [WIDTH-1:0] w_diff;
`ifdef SR_RETRY_EN
  logic             r_retried;
`endif

  // Masks are formed from the incoming word at accept and from the latched target in CHECK.
  assign w_tgt  = (r_state == S_IDLE) ? req.req_data : r_tgt;
  assign w_set  = w_tgt & ~q_in;
  assign w_rst  = ~w_tgt & q_in;
  assign w_diff = w_tgt ^ q_in;

  assign req.req_ready = (r_state == S_IDLE) && !rst;
  assign busy          = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tgt    <= '0;
      sr_s     <= '0;
      sr_r     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_mask <= '0;
`ifdef SR_RETRY_EN
      r_retried <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req.req_valid) begin
            r_tgt    <= req.req_data;
            err      <= 1'b0;
            err_mask <= '0;
`ifdef SR_RETRY_EN
            r_retried <= 1'b0;
`endif
            if ((w_set | w_rst) != '0) begin
              r_state <= S_DRIVE;
              sr_s    <= w_set;
              sr_r    <= w_rst;
              r_cnt   <= P_LD;
            end else begin
              r_state <= S_CHECK;
            end
          end
        end
        S_DRIVE: begin
          if (r_cnt == '0) begin
            sr_s <= '0;
            sr_r <= '0;
            if (SETTLE_CYCLES > 0) begin
              r_state <= S_SETTLE;
              r_cnt   <= S_LD;
            end else begin
              r_state <= S_CHECK;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_cnt == '0) r_state <= S_CHECK;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_CHECK: begin
`ifdef SR_RETRY_EN
          if ((w_diff != '0) && !r_retried) begin
            r_retried <= 1'b1;
            r_state   <= S_DRIVE;
            sr_s      <= w_set;
            sr_r      <= w_rst;
            r_cnt     <= P_LD;
          end else begin
            err_mask <= w_diff;
            err      <= |w_diff;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end
`else
          err_mask <= w_diff;
          err      <= |w_diff;
          done     <= 1'b1;
          r_state  <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Directed bench for sr_bank_writer with a behavioural SR bank model (q <= (q|s)&~r, optional stuck-0 bits).
module tb_sr_bank_writer;

  localparam int unsigned P = 2;
  localparam int unsigned S = 1;

  logic       clk;
  logic       rst;
  logic [7:0] bank;
  logic [7:0] stuck;
  logic [7:0] sr_s, sr_r, err_mask;
  logic       busy, done, err;

  int n_cmp;
  int n_bad;

  sr_bank_writer_if #(.WIDTH(8)) u_if ();

  sr_bank_writer #(
    .WIDTH(8),
    .PULSE_CYCLES(P),
    .SETTLE_CYCLES(S)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (u_if),
    .q_in     (bank),
    .sr_s     (sr_s),
    .sr_r     (sr_r),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) bank <= '0;
    else     bank <= ((bank | sr_s) & ~sr_r) & ~stuck;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("s_and_r", 32'(sr_s & sr_r), 32'd0);
      if (!busy) chk("idle_drive", 32'({sr_s, sr_r}), 32'd0);
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [7:0]  stuck;
    logic [7:0]  s;
    logic [7:0]  r;
    logic [7:0]  s2;
    logic [7:0]  r2;
    int unsigned lat;
    logic        e;
    logic [7:0]  mask;
    logic [7:0]  bank;
    logic        hold;
  } vec_t;

  vec_t vecs[6];

  task automatic do_txn(input vec_t v);
    int unsigned w;
    logic [7:0]  es, er;
    stuck = v.stuck;
    w = 0;
    while (!u_if.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(u_if.req_ready), 32'd1);
    u_if.req_valid = 1'b1;
    u_if.req_data  = v.data;
    @(posedge clk);
    #1;
    if (v.hold) u_if.req_data  = ~v.data;
    else        u_if.req_valid = 1'b0;
    for (int unsigned k = 1; k <= v.lat + 1; k++) begin
      @(negedge clk);
      es = '0;
      er = '0;
      if (k >= 1 && k <= P) begin
        es = v.s;
        er = v.r;
      end else if (k >= P + S + 2 && k <= 2 * P + S + 1) begin
        es = v.s2;
        er = v.r2;
      end
      chk("drive", 32'({sr_s, sr_r}), 32'({es, er}));
      chk("done", 32'(done), 32'(k == v.lat));
      if (k == v.lat) begin
        chk("err", 32'(err), 32'(v.e));
        chk("err_mask", 32'(err_mask), 32'(v.mask));
        chk("ready_at_done", 32'(u_if.req_ready), 32'd1);
        chk("bank", 32'(bank), 32'(v.bank));
      end
      if (k == v.lat + 1) chk("busy_after", 32'(busy), 32'd0);
      if (v.hold && k == v.lat - 1) u_if.req_valid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t fin;
    n_cmp = 0;
    n_bad = 0;
    // data stuck  s      r      s2     r2     lat e  mask   bank   hold
    vecs[0] = '{8'hA5, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 5, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[1] = '{8'h5A, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 5, 1'b0, 8'h00, 8'h5A, 1'b0};
    vecs[2] = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b0, 8'h00, 8'h5A, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 5, 1'b0, 8'h00, 8'h00, 1'b0};
`ifdef SR_RETRY_EN
    vecs[4] = '{8'hFF, 8'h08, 8'hFF, 8'h00, 8'h08, 8'h00, 9, 1'b1, 8'h08, 8'hF7, 1'b0};
`else
    vecs[4] = '{8'hFF, 8'h08, 8'hFF, 8'h00, 8'h00, 8'h00, 5, 1'b1, 8'h08, 8'hF7, 1'b0};
`endif
    vecs[5] = '{8'h08, 8'h00, 8'h08, 8'hF7, 8'h00, 8'h00, 5, 1'b0, 8'h00, 8'h08, 1'b1};

    rst = 1'b1;
    stuck = '0;
    u_if.req_valid = 1'b0;
    u_if.req_data  = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_vectors", 32'({sr_s, sr_r, err_mask}), 32'd0);
      chk("rst_flags", 32'({busy, done, err, u_if.req_ready}), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(u_if.req_ready), 32'd1);

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Reset during the first DRIVE cycle aborts the write with no lingering drive or done.
    u_if.req_valid = 1'b1;
    u_if.req_data  = 8'h80;
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_drive", 32'({sr_s, sr_r}), 32'h8008);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_vectors", 32'({sr_s, sr_r}), 32'd0);
    chk("abort_flags", 32'({busy, done, u_if.req_ready}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    fin = '{8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 5, 1'b0, 8'h00, 8'h0F, 1'b0};
    do_txn(fin);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
